// File: rtl/cic_comp_fir.sv
// cic_comp_fir: serial multiply-accumulate compensation FIR placed after a
// CIC decimator. One MAC per clock over a TAPS-deep circular sample buffer,
// round-half-up to the output width with saturation, one-cycle eno strobe.
// Optional 2:1 decimation is selected by defining CIC_COMP_FIR_DECI2_EN.
module cic_comp_fir #(
    parameter int W    = 10,
    parameter int CW   = 16,
    parameter int TAPS = 15,
    parameter logic signed [CW-1:0] COEF [TAPS] = '{
        -16'sd100,  16'sd200,  -16'sd400,  16'sd700,  -16'sd1200,
         16'sd2500, 16'sd6000,  16'sd9400, 16'sd6000,  16'sd2500,
        -16'sd1200, 16'sd700,  -16'sd400,  16'sd200,  -16'sd100
    }
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         eni,
    input  logic [W-1:0] in,
    output logic         eno,
    output logic [W-1:0] out,
    output logic         busy,
    output logic         ovf
);

    // Accumulator wide enough that a full pass of worst-case products cannot wrap.
    localparam int AW = W + CW + $clog2(TAPS);
    localparam int PW = $clog2(TAPS);
    // Width of the accumulator after dropping the CW-1 fractional bits.
    localparam int RW = AW - (CW - 1);
    localparam logic [PW-1:0] LAST = PW'(TAPS - 1);
    localparam logic signed [AW-1:0] HALF = {{(AW - 1){1'b0}}, 1'b1} << (CW - 2);
    localparam logic signed [RW-1:0] MAXV = RW'((2 ** (W - 1)) - 1);
    localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (W - 1)));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                state_q;
    logic signed [W-1:0]   buf_q [TAPS];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         tap_q;
    logic signed [AW-1:0]  acc_q;
    logic [W-1:0]          out_q;
    logic                  eno_q;
    logic                  busy_q;
    logic                  ovf_q;
`ifdef CIC_COMP_FIR_DECI2_EN
    logic                  phase_q;
`endif

    logic                  accept_s;
    logic                  drop_s;
    logic                  start_s;
    logic [PW-1:0]         wr_ptr_d;
    logic [PW-1:0]         rd_ptr_d;
    logic signed [W+CW-1:0] prod_s;
    logic signed [AW-1:0]  acc_d;

    // Round half up (add half an LSB, floor) and clamp to the W-bit range.
    function automatic logic [W-1:0] round_sat(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] biased;
        logic signed [RW-1:0] q;
        logic [W-1:0]         r;
        biased = a + HALF;
        q      = biased[AW-1:CW-1];
        if (q > MAXV) begin
            r = MAXV[W-1:0];
        end else if (q < MINV) begin
            r = MINV[W-1:0];
        end else begin
            r = q[W-1:0];
        end
        return r;
    endfunction

    assign accept_s = eni && (state_q == IDLE);
    assign drop_s   = eni && (state_q != IDLE);
`ifdef CIC_COMP_FIR_DECI2_EN
    assign start_s  = accept_s && phase_q;
`else
    assign start_s  = accept_s;
`endif

    // Pointer stepping: write pointer walks forward, read pointer walks back in time.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ptr_q == LAST) begin
            wr_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_ptr_q == '0) begin
            rd_ptr_d = LAST;
        end else begin
            rd_ptr_d = rd_ptr_q - PW'(1);
        end
    end

    // One tap product x[n-k]*COEF[k], sign-extended into the accumulator.
    always_comb begin
        prod_s = buf_q[rd_ptr_q] * COEF[tap_q];
        acc_d  = acc_q + {{(AW - W - CW){prod_s[W+CW-1]}}, prod_s};
    end

    // Sample capture, FSM sequencing, MAC datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            for (int i = 0; i < TAPS; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tap_q    <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            eno_q    <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef CIC_COMP_FIR_DECI2_EN
            phase_q  <= 1'b0;
`endif
        end else begin
            // A strobe while busy is lost; remember it until reset.
            ovf_q <= ovf_q | drop_s;
            if (accept_s) begin
                buf_q[wr_ptr_q] <= in;
                wr_ptr_q        <= wr_ptr_d;
`ifdef CIC_COMP_FIR_DECI2_EN
                phase_q         <= ~phase_q;
`endif
            end
            case (state_q)
                IDLE: begin
                    eno_q <= 1'b0;
                    if (start_s) begin
                        state_q  <= MAC;
                        busy_q   <= 1'b1;
                        acc_q    <= '0;
                        tap_q    <= '0;
                        rd_ptr_q <= wr_ptr_q;
                    end
                end
                MAC: begin
                    acc_q    <= acc_d;
                    rd_ptr_q <= rd_ptr_d;
                    if (tap_q == LAST) begin
                        state_q <= ROUND;
                        tap_q   <= '0;
                    end else begin
                        tap_q   <= tap_q + PW'(1);
                    end
                end
                ROUND: begin
                    out_q   <= round_sat(acc_q);
                    eno_q   <= 1'b1;
                    state_q <= OUT;
                end
                OUT: begin
                    eno_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    eno_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign eno  = eno_q;
    assign out  = out_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/cic_comp_fir.md
CIC_COMP_FIR -- requirements
Module: cic_comp_fir

Interface
REQ-001 SHALL have parameter W, default 10: input/output sample width, signed two's complement.
REQ-002 SHALL have parameter CW, default 16: coefficient width, signed Q1.(CW-1).
REQ-003 SHALL have parameter TAPS, default 15: number of taps, odd, 3..63.
REQ-004 SHALL have parameter COEF, an array of TAPS signed CW-bit values; COEF[k] is the weight for x[n-k].
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port eni, input, 1 bit: one-cycle input strobe, driven by the upstream CIC decimator output strobe.
REQ-008 SHALL have port in, input, W bits: input sample, valid when eni=1.
REQ-009 SHALL have port eno, output, 1 bit: one-cycle output-valid strobe.
REQ-010 SHALL have port out, output, W bits: compensated sample, held until the next eno.
REQ-011 SHALL have port busy, output, 1 bit: high while the filter is not in IDLE.
REQ-012 SHALL have port ovf, output, 1 bit: sticky overrun flag.

Function
REQ-013 SHALL store accepted samples in a TAPS-deep circular buffer with a write pointer that wraps from TAPS-1 to 0.
REQ-014 SHALL accept a sample only when eni=1 and state is IDLE.
REQ-015 SHALL drop a sample that arrives with eni=1 while not in IDLE, leave the buffer and pointer unchanged, and set ovf=1 until reset.
REQ-016 SHALL run an FSM with states IDLE, MAC, ROUND, OUT.
- IDLE -> MAC: on an accepted sample that is a compute phase.
- MAC -> ROUND: after TAPS cycles.
- ROUND -> OUT: after 1 cycle.
- OUT -> IDLE: after 1 cycle.
REQ-017 SHALL, in MAC, perform one multiply-accumulate per cycle, k = 0..TAPS-1: acc += x[n-k]*COEF[k], with x[n] being the newest stored sample.
REQ-018 SHALL clear the accumulator on entry to MAC.
REQ-019 SHALL use an accumulator width of W+CW+$clog2(TAPS) bits, so no intermediate overflow is possible.
REQ-020 SHALL, in ROUND, compute out = round-half-up(acc / 2^(CW-1)) and saturate it to [-2^(W-1), 2^(W-1)-1].
REQ-021 SHALL, in OUT, update out and pulse eno high for exactly one cycle.
- Latency is eni cycle to eno cycle = TAPS+2 clocks.
REQ-022 SHALL require upstream eni spacing >= TAPS+3 clocks for overrun-free operation; smaller spacing is handled per REQ-015.
REQ-023 SHALL treat buffer entries that have not yet been written since reset as 0.

Reset
REQ-024 SHALL, while rst=1, asynchronously force: state=IDLE, buffer contents 0, write pointer 0, accumulator 0, decimation phase 0, out=0, eno=0, busy=0, ovf=0.
REQ-025 SHALL, on reset asserted mid-MAC, abandon the computation with no eno issued; the first eno after reset comes only from samples accepted after reset.

Configuration
REQ-026 SHALL use macro CIC_COMP_FIR_DECI2_EN to select decimation.
- Defined: the block decimates by 2. A phase bit toggles on every accepted sample, and only accepted samples with phase=1 (the 2nd, 4th, ... after reset) start MAC. Phase-0 samples are written to the buffer only and keep state IDLE.
- Not defined: there is no phase bit, and every accepted sample starts MAC (rate 1:1).

Verification
REQ-027 SHALL cover impulse response: TAPS=15, macro undefined, in=2^(W-1)-1 once then 0, eni every 20 clocks -> the successive outs equal COEF[k]*511/2^15 rounded, for k=0..14, then 0.
REQ-028 SHALL cover DC saturation: all COEF=0x4000 (0.5), in=+511 held -> out saturates at +511 once the buffer is full; in=-512 held -> out=-512.
REQ-029 SHALL cover latency: a single accepted eni at cycle t -> eno at cycle t+17 (TAPS=15), busy high for cycles t+1..t+17, eno pulse width 1.
REQ-030 SHALL cover overrun: a second eni 5 clocks after the first -> that sample is dropped, ovf=1 and stays 1, and the first computation's output is unaffected.
REQ-031 SHALL cover reset mid-MAC: rst pulsed 6 clocks into MAC -> no eno, all outputs 0, and the next impulse test passes from a clean buffer.
REQ-032 SHALL cover decimation: macro defined, 8 accepted samples -> exactly 4 eno pulses, aligned to the 2nd, 4th, 6th and 8th samples.
